// File: rtl/m_s2p_ctrl_if.sv
// Handshake bundle between the frame sequencer, the deserializer
// and the downstream word consumer.
interface m_s2p_ctrl_if #(
  parameter int WORD  = 8,
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             s2p_start;
  logic             s2p_done;
  logic [WORD-1:0]  s2p_parallel;
  logic [WORD-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             frame_done;
  logic             err_timeout;
  logic             err_clr;

  modport slave (
    input  req_valid, req_len, s2p_done,
    input  s2p_parallel, out_ready, err_clr,
    output req_ready, s2p_start, out_data,
    output out_valid, out_last, busy,
    output frame_done, err_timeout
  );

  modport master (
    output req_valid, req_len, s2p_done,
    output s2p_parallel, out_ready, err_clr,
    input  req_ready, s2p_start, out_data,
    input  out_valid, out_last, busy,
    input  frame_done, err_timeout
  );
endinterface

// File: rtl/m_s2p_ctrl.sv
// Frame sequencer for the m_s_to_p deserializer: starts one
// conversion per word, captures it and streams it downstream.
module m_s2p_ctrl #(
  parameter int WORD    = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  m_s2p_ctrl_if.slave bus
);
  localparam int BW = $clog2(WORD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT_DONE,
    PUSH,
    FINISH,
    ERR
  } state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [TW-1:0]    to_cnt;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len;
  logic [WORD-1:0]  data;
  logic             valid;
  logic             last;
  logic             start;
  logic             done;
  logic             err;
  logic             timeout_hit;

  // A done arriving on the final slot beats the timeout.
  assign timeout_hit = (state == WAIT_DONE)
                    && !bus.s2p_done
                    && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      word_cnt <= '0;
      len      <= '0;
      data     <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      start    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      if (timeout_hit) begin
        err <= 1'b1;
      end else if (bus.err_clr) begin
        err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.req_valid && !err) begin
            len      <= bus.req_len;
            word_cnt <= '0;
            if (bus.req_len == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= START;
              start <= 1'b1;
            end
          end
        end
        START: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(WORD - 1)) begin
            to_cnt <= '0;
            state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.s2p_done) begin
            data     <= bus.s2p_parallel;
            valid    <= 1'b1;
            word_cnt <= word_cnt + LEN_W'(1);
            last     <= (word_cnt + LEN_W'(1)) == len;
            state    <= PUSH;
          end else if (timeout_hit) begin
            state <= ERR;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        PUSH: begin
          if (bus.out_ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (word_cnt < len) begin
              state <= START;
              start <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        ERR: begin
          valid <= 1'b0;
          last  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE) && !err;
  assign bus.busy        = (state != IDLE);
  assign bus.s2p_start   = start;
  assign bus.out_data    = data;
  assign bus.out_valid   = valid;
  assign bus.out_last    = last;
  assign bus.frame_done  = done;
  assign bus.err_timeout = err;
endmodule
